// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg
//   Shared constants for the host-side sequencer:
//   - FSM state encodings (3-bit legacy-compatible codes)
//   - bit positions inside the 8-bit status word
package ctrl_seq_pkg;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLR   = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_PRES  = 3'd3;
   localparam logic [2:0] S_GUARD = 3'd4;
   localparam logic [2:0] S_WAIT  = 3'd5;
   localparam logic [2:0] S_FIN   = 3'd6;

   // status = {job_cnt[3:0], 1'b0, hold_valid, ovf, active}
   localparam int unsigned STAT_ACTIVE  = 0;
   localparam int unsigned STAT_OVF     = 1;
   localparam int unsigned STAT_HOLD    = 2;
   localparam int unsigned STAT_JOB_LSB = 4;

endpackage

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if
//   Bundles the sequencer's host/engine signals.
//   master : host side (drives data_in, in, rd_en, busy, ack)
//   slave  : sequencer side (drives in_rdy, tx, acc, clear, sel, out, done, status)
interface ctrl_seq_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned SEL_W  = 4
);
   logic [DATA_W-1:0] data_in;
   logic              in;
   logic              in_rdy;
   logic              rd_en;
   logic              busy;
   logic              ack;
   logic              tx;
   logic              acc;
   logic              clear;
   logic [SEL_W-1:0]  sel;
   logic              out;
   logic              done;
   logic [7:0]        status;

   modport master (
      output data_in, in, rd_en, busy, ack,
      input  in_rdy, tx, acc, clear, sel, out, done, status
   );

   modport slave (
      input  data_in, in, rd_en, busy, ack,
      output in_rdy, tx, acc, clear, sel, out, done, status
   );
endinterface

// File: rtl/ctrl_seq_hold_reg.sv
// ctrl_hold_reg
//   One-entry holding buffer for a received word.
//   clk, nRst  : clock / async active-low reset (empties the buffer)
//   push       : store push_data, mark valid
//   pop        : release the entry (push wins if both are asserted)
//   data/valid : stored word and occupancy flag
module ctrl_hold_reg #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] push_data,
   output logic [DATA_W-1:0] data,
   output logic              valid
);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (push) begin
         valid <= 1'b1;
         data  <= push_data;
      end else if (pop) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq
//   Sequencer between the UART receive path and the accumulator engine.
//   Per job: one clear cycle, DATA_W serial bits MSB-first (acc=1), then
//   optionally walks sel over N_OUT slots pulsing out, gated by busy.
//   clk, nRst : clock / async active-low reset
//   bus       : ctrl_seq_if slave (word input, handshakes, engine outputs, status)
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned N_OUT  = 16,
   parameter int unsigned SEL_W  = 4
) (
   input  logic       clk,
   input  logic       nRst,
   ctrl_seq_if.slave  bus
);

   localparam int unsigned BIT_W = $clog2(DATA_W + 1);

   logic [2:0]        state;
   logic [DATA_W-1:0] shreg;
   logic [BIT_W-1:0]  bitcnt;
   logic [SEL_W-1:0]  sel_q;
   logic              job_rd;
   logic              tx_q;
   logic              ovf;
   logic [3:0]        job_cnt;

   logic              hold_valid;
   logic [DATA_W-1:0] hold_data;
   logic              accept, drop, push, pop, start;
   logic [DATA_W-1:0] start_word;

   // A word is taken only while the buffer is empty; in IDLE a buffered
   // word has priority and a fresh one goes straight to the engine.
   always_comb begin
      accept     = bus.in && !hold_valid;
      drop       = bus.in && hold_valid;
      pop        = (state == S_IDLE) && hold_valid;
      push       = accept && (state != S_IDLE);
      start      = (state == S_IDLE) && (hold_valid || accept);
      start_word = hold_valid ? hold_data : bus.data_in;
   end

   ctrl_hold_reg #(.DATA_W(DATA_W)) u_hold (
      .clk       (clk),
      .nRst      (nRst),
      .push      (push),
      .pop       (pop),
      .push_data (bus.data_in),
      .data      (hold_data),
      .valid     (hold_valid)
   );

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state   <= S_IDLE;
         shreg   <= '0;
         bitcnt  <= '0;
         sel_q   <= '0;
         job_rd  <= 1'b0;
         tx_q    <= 1'b0;
         job_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               state  <= S_CLR;
               shreg  <= start_word;
               job_rd <= bus.rd_en;
            end
            // tx is registered one cycle ahead so it holds the last bit after SHIFT.
            S_CLR: begin
               state  <= S_SHIFT;
               bitcnt <= '0;
               tx_q   <= shreg[DATA_W-1];
               shreg  <= shreg << 1;
            end
            S_SHIFT: begin
               if (bitcnt == BIT_W'(DATA_W - 1)) begin
                  state <= job_rd ? S_PRES : S_FIN;
               end else begin
                  bitcnt <= bitcnt + 1'b1;
                  tx_q   <= shreg[DATA_W-1];
                  shreg  <= shreg << 1;
               end
            end
            S_PRES:  state <= S_GUARD;
            S_GUARD: state <= S_WAIT;
            S_WAIT: if (!bus.busy) begin
               if (sel_q == SEL_W'(N_OUT - 1)) begin
                  state <= S_FIN;
               end else begin
                  sel_q <= sel_q + 1'b1;
                  state <= S_PRES;
               end
            end
            S_FIN: begin
               job_cnt <= job_cnt + 1'b1;
               sel_q   <= '0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Sticky overflow; a drop in the same cycle as ack keeps it set.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         ovf <= 1'b0;
      end else if (drop) begin
         ovf <= 1'b1;
      end else if (bus.ack) begin
         ovf <= 1'b0;
      end
   end

   always_comb begin
      bus.status                         = '0;
      bus.status[STAT_ACTIVE]            = (state != S_IDLE);
      bus.status[STAT_OVF]               = ovf;
      bus.status[STAT_HOLD]              = hold_valid;
      bus.status[STAT_JOB_LSB +: 4]      = job_cnt;
   end

   assign bus.in_rdy = !hold_valid;
   assign bus.tx     = tx_q;
   assign bus.acc    = (state == S_SHIFT);
   assign bus.clear  = (state == S_CLR);
   assign bus.out    = (state == S_PRES);
   assign bus.done   = (state == S_FIN);
   assign bus.sel    = sel_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq
//   Directed bench for ctrl_seq (DATA_W=8, N_OUT=16, SEL_W=4).
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ctrl_seq;

   logic clk  = 1'b0;
   logic nRst = 1'b0;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;
   int unsigned exp_jobs = 0;
   logic        exp_ovf  = 1'b0;

   always #5 clk = ~clk;

   ctrl_seq_if #(.DATA_W(8), .SEL_W(4)) bus ();

   ctrl_seq #(.DATA_W(8), .N_OUT(16), .SEL_W(4)) u_dut (
      .clk  (clk),
      .nRst (nRst),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] exp_status(input logic hold, input logic active);
      logic [3:0] jc;
      jc = 4'(exp_jobs);
      return {jc, 1'b0, hold, exp_ovf, active};
   endfunction

   task automatic wait_done(input int unsigned budget);
      logic seen;
      seen = 1'b0;
      for (int unsigned i = 0; i < budget; i++) begin
         tick();
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", 32'(seen), 32'd1);
   endtask

   // Full job with busy=0 and an empty holding buffer; ends in the IDLE cycle after FIN.
   task automatic run_job(input logic [7:0] d, input logic rd);
      bus.data_in = d;
      bus.in      = 1'b1;
      bus.rd_en   = rd;
      tick();
      bus.in = 1'b0;
      check("c0_clear", 32'(bus.clear), 32'd1);
      check("c0_acc",   32'(bus.acc),   32'd0);
      for (int k = 0; k < 8; k++) begin
         tick();
         check("sh_acc", 32'({bus.acc, bus.clear}), 32'b10);
         check("sh_tx",  32'(bus.tx), 32'(d[7-k]));
      end
      if (rd) begin
         for (int unsigned s = 0; s < 16; s++) begin
            tick();
            check("pres_out", 32'({bus.out, bus.acc}), 32'b10);
            check("pres_sel", 32'(bus.sel), s);
            tick();
            check("guard_out", 32'(bus.out), 32'd0);
            tick();
            check("wait_out", 32'(bus.out), 32'd0);
         end
      end
      tick();
      check("fin_done", 32'(bus.done), 32'd1);
      check("fin_out",  32'(bus.out),  32'd0);
      tick();
      exp_jobs++;
      check("end_done",   32'(bus.done), 32'd0);
      check("end_sel",    32'(bus.sel),  32'd0);
      check("end_tx",     32'(bus.tx),   32'(d[0]));
      check("end_status", 32'(bus.status), 32'(exp_status(1'b0, 1'b0)));
   endtask

   task automatic pulse_reset();
      nRst = 1'b0;
      #1;
      exp_jobs = 0;
      exp_ovf  = 1'b0;
      check("rst_status", 32'(bus.status), 32'h00);
      check("rst_rdy",    32'(bus.in_rdy), 32'd1);
      check("rst_strobe", 32'({bus.clear, bus.acc, bus.out, bus.done, bus.tx}), 32'd0);
      check("rst_sel",    32'(bus.sel), 32'd0);
      #2;
      nRst = 1'b1;
   endtask

   initial begin
      bus.data_in = '0;
      bus.in      = 1'b0;
      bus.rd_en   = 1'b0;
      bus.busy    = 1'b0;
      bus.ack     = 1'b0;
      #12;
      nRst = 1'b1;
      tick();

      // 1: idle after reset
      for (int i = 0; i < 100; i++) begin
         check("idle", 32'({bus.status, bus.in_rdy, bus.clear, bus.acc, bus.out, bus.done, bus.tx, bus.sel}),
               32'({8'h00, 1'b1, 5'b00000, 4'h0}));
         tick();
      end

      // 2: full read job
      run_job(8'hB4, 1'b1);
      check("job1_cnt", 32'(bus.status[7:4]), 32'd1);

      // 3: busy stalls slot advance
      bus.data_in = 8'hB4;
      bus.in      = 1'b1;
      bus.rd_en   = 1'b1;
      tick();
      bus.in = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      tick();
      check("b_out0", 32'({bus.out, bus.sel}), 32'({1'b1, 4'd0}));
      bus.busy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("b_stall", 32'({bus.out, bus.sel}), 32'({1'b0, 4'd0}));
         if (i == 0) bus.busy = 1'b0;
         if (i == 0) bus.busy = 1'b1;
      end
      bus.busy = 1'b0;
      tick();
      check("b_out1", 32'({bus.out, bus.sel}), 32'({1'b1, 4'd1}));
      wait_done(100);
      tick();
      exp_jobs++;
      check("b_status", 32'(bus.status), 32'(exp_status(1'b0, 1'b0)));

      // 4: load-only job
      run_job(8'h01, 1'b0);

      // 5: hold buffer, overflow and ack
      bus.data_in = 8'hA5;
      bus.in      = 1'b1;
      bus.rd_en   = 1'b0;
      tick();
      bus.data_in = 8'h3C;
      tick();
      check("h_rdy", 32'(bus.in_rdy), 32'd0);
      bus.data_in = 8'h11;
      tick();
      bus.data_in = 8'h22;
      tick();
      bus.in  = 1'b0;
      exp_ovf = 1'b1;
      check("h_status", 32'(bus.status), 32'(exp_status(1'b1, 1'b1)));
      wait_done(20);
      tick();
      exp_jobs++;
      check("h_idle", 32'(bus.status), 32'(exp_status(1'b1, 1'b0)));
      tick();
      check("h_clr", 32'({bus.clear, bus.in_rdy}), 32'b11);
      check("h_pop", 32'(bus.status), 32'(exp_status(1'b0, 1'b1)));
      begin
         logic [7:0] w;
         w = 8'h3C;
         for (int k = 0; k < 8; k++) begin
            tick();
            check("h_tx", 32'(bus.tx), 32'(w[7-k]));
         end
      end
      wait_done(20);
      tick();
      exp_jobs++;
      check("h_end", 32'(bus.status), 32'(exp_status(1'b0, 1'b0)));
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      exp_ovf = 1'b0;
      check("ack_clr", 32'(bus.status), 32'(exp_status(1'b0, 1'b0)));
      bus.data_in = 8'h0F;
      bus.in      = 1'b1;
      tick();
      bus.data_in = 8'h55;
      tick();
      bus.data_in = 8'h66;
      bus.ack     = 1'b1;
      tick();
      bus.in  = 1'b0;
      bus.ack = 1'b0;
      exp_ovf = 1'b1;
      check("ack_vs_ovf", 32'(bus.status), 32'(exp_status(1'b1, 1'b1)));
      wait_done(20);
      tick();
      exp_jobs++;
      wait_done(20);
      tick();
      exp_jobs++;
      check("h2_end", 32'(bus.status), 32'(exp_status(1'b0, 1'b0)));

      // 6: reset in SHIFT (with a held word) and in WAIT
      bus.data_in = 8'hB4;
      bus.in      = 1'b1;
      bus.rd_en   = 1'b1;
      tick();
      bus.data_in = 8'h77;
      tick();
      bus.in = 1'b0;
      tick();
      check("r_pre", 32'(bus.status), 32'(exp_status(1'b1, 1'b1)));
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         tick();
         check("r_nojob", 32'({bus.status, bus.clear}), 32'd0);
      end
      bus.data_in = 8'hB4;
      bus.in      = 1'b1;
      bus.busy    = 1'b1;
      tick();
      bus.in = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      tick();
      check("r_pres", 32'(bus.out), 32'd1);
      tick();
      tick();
      tick();
      pulse_reset();
      bus.busy = 1'b0;
      tick();
      run_job(8'hC3, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
